keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Consumer side of the keypad scanner: takes the raw per-cycle key bitmap and the one-hot column strobe, and assembles them into complete scan frames. It debounces the frames and turns a clean single-key press into one encoded key event, delivered on a valid/ready handshake. It sits between the keypad scanner and the frequency-setting control logic.

## Interface
- N_COLUMN, 4, number of keypad columns (≥2)
- N_ROW, 4, number of keypad rows
- DEBOUNCE_FRAMES, 8, consecutive identical frames required before a key state is accepted (≥2)
- KEY_W, $clog2(N_COLUMN*N_ROW), derived localparam; key code width

- clk  input  1  system clock; single clock domain
- rst_n  input  1  reset, asynchronous, active-low
- column  input  N_COLUMN  one-hot column strobe from the scanner; exactly one bit high per cycle
- in_keys  input  N_COLUMN*N_ROW  raw key bitmap from the scanner; only bits of the strobed column can be 1
- key_code  output  KEY_W  bit index of the pressed key; stable while key_valid=1
- key_valid  output  1  key event pending
- key_ready  input  1  consumer accepts the event when key_valid && key_ready at a rising edge
- key_held  output  1  level; debounced key state is non-zero
- multi_key  output  1  level; debounced key state has more than one bit set

## Operation
- **Frame accumulation.**
  - frame_acc is ORed with in_keys every cycle.
  - A frame completes on a cycle with column[N_COLUMN-1]=1: frame = frame_acc | in_keys, and frame_acc is cleared on that edge.
  - The first frame after reset may be partial. It is treated like any other frame.
- **Debounce**, at each frame-completion edge:
  - If frame == prev_frame, stable_cnt increments, saturating at DEBOUNCE_FRAMES-1. Otherwise stable_cnt is cleared.
  - prev_frame <= frame.
  - When frame == prev_frame and stable_cnt == DEBOUNCE_FRAMES-2, stable_keys <= frame. stable_keys therefore updates only after DEBOUNCE_FRAMES identical consecutive frames.
  - key_held = |stable_keys. multi_key = stable_keys has 2 or more bits set. Both are registered from stable_keys.
- **FSM.** States are IDLE, VALID, RELEASE.
  - IDLE, stable_keys one-hot: key_code <= index of the set bit, key_valid <= 1, go to VALID.
  - IDLE, multiple bits set: go to RELEASE. No event is emitted; the press is rejected.
  - IDLE, stable_keys zero: stay in IDLE.
  - VALID: hold key_code and key_valid until key_ready. On accept, key_valid <= 0 and go to RELEASE. A key release during VALID does not cancel the event.
  - RELEASE: wait for stable_keys == 0, then go to IDLE. Auto-repeat is not supported. Adding a second key while one is held produces no new event.
- key_ready while key_valid=0 is ignored.
- **Reset.** Every register clears immediately: key_valid=0, key_code=0, key_held=0, multi_key=0, state=IDLE, frame_acc, prev_frame, stable_keys and stable_cnt all 0. A reset asserted mid-event discards the pending event.

## Timing
- One frame = N_COLUMN cycles. Debounce window = DEBOUNCE_FRAMES × N_COLUMN cycles.
- stable_keys updates at the frame-completion edge of the DEBOUNCE_FRAMES-th identical frame.
- key_valid, key_code, key_held and multi_key rise 1 cycle after that edge.
- Accept: key_valid is low the cycle after the edge at which key_valid && key_ready is sampled. Maximum throughput is one event per press/release cycle.
- Release detection needs DEBOUNCE_FRAMES identical all-zero frames. IDLE is reached 1 cycle after stable_keys becomes 0.
- A single differing frame restarts the debounce count. Glitches shorter than one frame within a column slot appear in that frame only.

## Structure
- Shared package/include keypad_pkg holds:
  - the FSM state encoding (IDLE/VALID/RELEASE);
  - default N_COLUMN, N_ROW and DEBOUNCE_FRAMES;
  - the KEY_W derivation.
- Sub-module keypad_debouncer contains frame accumulation, prev_frame, stable_cnt and stable_keys. Its output is stable_keys.
- The top level holds the FSM, the one-hot-to-index encoder and the status outputs.

## Test plan
- **Clean press.** N_COLUMN=N_ROW=4, DEBOUNCE_FRAMES=4; scanner model with key 5 held and key_ready=0 → key_valid=1 with key_code=5, 1 cycle after the 4th identical frame. key_valid is held until key_ready is pulsed, then drops. No second event while key 5 stays held.
- **Bounce.** Key 9 toggles every frame for 3 frames, then holds → exactly one event, key_code=9, after 4 stable frames following the last toggle.
- **Multi-key.** Keys 2 and 7 pressed together → multi_key=1, key_held=1, no key_valid. Releasing key 7 only → still no event. Releasing all, then pressing key 7 → event with key_code=7.
- **Release during VALID.** Key 0 pressed, then released before key_ready → key_valid stays 1 with key_code=0 until accepted. The FSM then returns to IDLE with no further event.
- **Reset mid-event.** rst_n low asynchronously while key_valid=1 → all outputs 0 immediately, without a clock edge. With the key still held after reset, a fresh event appears after a full debounce window.
- **Wrap/last key.** Key 15 (column 3, row 3) held → key_code=15. Verify frame completion on column[3] and that frame_acc is cleared each frame.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad decoder: FSM state encoding, default
// geometry / debounce depth, and the key-code width derivation.
package keypad_pkg;

    localparam int unsigned N_COLUMN_DEFAULT        = 4;
    localparam int unsigned N_ROW_DEFAULT           = 4;
    localparam int unsigned DEBOUNCE_FRAMES_DEFAULT = 8;

    // Event FSM: wait for a press, hold a pending event, wait for release.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VALID   = 2'd1,
        ST_RELEASE = 2'd2
    } key_state_t;

    // Width of a key index; never below one bit.
    function automatic int unsigned calc_key_w(input int unsigned n_keys);
        return (n_keys > 1) ? $clog2(n_keys) : 1;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Assembles per-cycle key bitmaps into scan frames (frame closes on the last
// column strobe) and accepts a frame as the stable key state once
// DEBOUNCE_FRAMES identical frames have been seen in a row.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   column        one-hot column strobe from the scanner
//   in_keys       raw key bitmap (bits of the strobed column only)
//   stable_keys   debounced key state
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned N_COLUMN        = N_COLUMN_DEFAULT,
    parameter int unsigned N_ROW           = N_ROW_DEFAULT,
    parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_COLUMN-1:0]          column,
    input  logic [N_COLUMN*N_ROW-1:0]    in_keys,
    output logic [N_COLUMN*N_ROW-1:0]    stable_keys
);

    localparam int unsigned N_KEYS = N_COLUMN * N_ROW;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_FRAMES - 2);

    logic [N_KEYS-1:0] frame_acc;
    logic [N_KEYS-1:0] prev_frame;
    logic [CNT_W-1:0]  stable_cnt;

    logic              frame_done;
    logic [N_KEYS-1:0] frame;
    logic              frame_same;

    // Only the last strobe bit marks frame completion; the rest are consumed
    // here so the full strobe can stay on the port.
    logic unused_column_bits;
    assign unused_column_bits = ^column[N_COLUMN-2:0];

    assign frame_done = column[N_COLUMN-1];
    assign frame      = frame_acc | in_keys;
    assign frame_same = (frame == prev_frame);

    // Frame accumulation and debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_acc   <= '0;
            prev_frame  <= '0;
            stable_cnt  <= '0;
            stable_keys <= '0;
        end else if (frame_done) begin
            frame_acc  <= '0;
            prev_frame <= frame;
            if (frame_same) begin
                if (stable_cnt != CNT_MAX) begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
                // Counter at ACCEPT plus this matching frame = DEBOUNCE_FRAMES in a row.
                if (stable_cnt == CNT_ACCEPT) begin
                    stable_keys <= frame;
                end
            end else begin
                stable_cnt <= '0;
            end
        end else begin
            frame_acc <= frame;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad decoder top: debounces scanner frames and turns a clean single-key
// press into one key event on a valid/ready handshake. Multi-key presses are
// rejected; a new event needs a full release first.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   column        one-hot column strobe from the scanner
//   in_keys       raw key bitmap from the scanner
//   key_code      index of the pressed key, stable while key_valid
//   key_valid     key event pending
//   key_ready     consumer accepts the event
//   key_held      debounced key state non-zero
//   multi_key     debounced key state has two or more keys
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned N_COLUMN        = N_COLUMN_DEFAULT,
    parameter int unsigned N_ROW           = N_ROW_DEFAULT,
    parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [N_COLUMN-1:0]                        column,
    input  logic [N_COLUMN*N_ROW-1:0]                  in_keys,
    output logic [calc_key_w(N_COLUMN*N_ROW)-1:0]      key_code,
    output logic                                       key_valid,
    input  logic                                       key_ready,
    output logic                                       key_held,
    output logic                                       multi_key
);

    localparam int unsigned N_KEYS = N_COLUMN * N_ROW;
    localparam int unsigned KEY_W  = calc_key_w(N_KEYS);

    logic [N_KEYS-1:0] stable_keys;

    key_state_t        state_q;
    key_state_t        state_d;
    logic              key_valid_d;
    logic [KEY_W-1:0]  key_code_d;

    logic              keys_zero;
    logic              keys_multi;
    logic [KEY_W-1:0]  onehot_idx;

    keypad_debouncer #(
        .N_COLUMN        (N_COLUMN),
        .N_ROW           (N_ROW),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .column      (column),
        .in_keys     (in_keys),
        .stable_keys (stable_keys)
    );

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign keys_zero  = (stable_keys == '0);
    assign keys_multi = ((stable_keys & (stable_keys - N_KEYS'(1))) != '0);

    // One-hot to index; only consulted when exactly one bit is set.
    always_comb begin
        onehot_idx = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (stable_keys[i]) begin
                onehot_idx = KEY_W'(i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid;
        key_code_d  = key_code;
        case (state_q)
            ST_IDLE: begin
                if (!keys_zero) begin
                    if (keys_multi) begin
                        state_d = ST_RELEASE;
                    end else begin
                        key_code_d  = onehot_idx;
                        key_valid_d = 1'b1;
                        state_d     = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (key_ready) begin
                    key_valid_d = 1'b0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (keys_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                key_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
            key_held  <= !keys_zero;
            multi_key <= keys_multi;
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: scanner model drives rotating column strobes,
// a behavioural model predicts outputs cycle by cycle, and directed
// scenarios pin key timings and event counts with literal values.
module tb_keypad_decoder;

    localparam int unsigned NC = 4;
    localparam int unsigned NR = 4;
    localparam int unsigned DF = 4;
    localparam int unsigned NK = NC * NR;
    localparam int unsigned KW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] column;
    logic [NK-1:0] in_keys;
    logic [KW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;
    logic          key_held;
    logic          multi_key;

    always #5 clk = ~clk;

    keypad_decoder #(
        .N_COLUMN        (NC),
        .N_ROW           (NR),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .column    (column),
        .in_keys   (in_keys),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    int            checks;
    int            failures;
    int            col_idx;
    logic [NK-1:0] pressed;
    int            dut_events;
    int            last_code;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Key k lives in column k / NR, row k % NR.
    function automatic logic [NK-1:0] col_mask(input int c);
        logic [NK-1:0] m;
        m = '0;
        for (int r = 0; r < int'(NR); r++) m[c*NR + r] = 1'b1;
        return m;
    endfunction

    function automatic logic [NK-1:0] key_bit(input int k);
        logic [NK-1:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic drive();
        column  = NC'(1) << col_idx;
        in_keys = pressed & col_mask(col_idx);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            col_idx = (col_idx + 1) % NC;
            drive();
        end
    endtask

    task automatic align();
        while (col_idx != 0) tick(1);
    endtask

    task automatic accept();
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    task automatic press(input logic [NK-1:0] keys);
        pressed = keys;
        drive();
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!key_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, int'(key_valid), 1);
    endtask

    // Accepted events as seen at the handshake.
    always @(posedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            dut_events++;
            last_code = int'(key_code);
        end
    end

    // Behavioural model: last DF frames kept as a window; the stable state
    // follows the frame once the whole window agrees. Events: one per press
    // of exactly one key, then silence until everything is released.
    logic [NK-1:0] m_acc;
    logic [NK-1:0] m_stable;
    logic [NK-1:0] hist [DF];
    int            hist_n;
    logic          m_held, m_multi, m_valid, m_busy;
    int            m_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = '0; m_stable = '0; hist_n = 0;
            m_held = 0; m_multi = 0; m_valid = 0; m_busy = 0; m_code = 0;
        end else begin
            logic [NK-1:0] s;
            logic [NK-1:0] f;
            int            ones;
            bit            same;
            s    = m_stable;
            ones = $countones(s);
            m_held  = (ones > 0);
            m_multi = (ones >= 2);
            if (m_valid) begin
                if (key_ready) m_valid = 0;
            end else if (m_busy) begin
                if (ones == 0) m_busy = 0;
            end else if (ones > 0) begin
                m_busy = 1;
                if (ones == 1) begin
                    m_valid = 1;
                    for (int i = 0; i < int'(NK); i++) if (s[i]) m_code = i;
                end
            end
            if (column[NC-1]) begin
                f = m_acc | in_keys;
                m_acc = '0;
                for (int i = 0; i < int'(DF) - 1; i++) hist[i] = hist[i+1];
                hist[DF-1] = f;
                if (hist_n < int'(DF)) hist_n++;
                same = (hist_n == int'(DF));
                for (int i = 0; i < int'(DF); i++) if (hist[i] != f) same = 0;
                if (same) m_stable = f;
            end else begin
                m_acc = m_acc | in_keys;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_key_valid", int'(key_valid), int'(m_valid));
            chk("cyc_key_held",  int'(key_held),  int'(m_held));
            chk("cyc_multi_key", int'(multi_key), int'(m_multi));
            if (m_valid) chk("cyc_key_code", int'(key_code), m_code);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, failures=%0d", failures);
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; dut_events = 0; last_code = -1;
        rst_n = 1'b0; key_ready = 1'b0; pressed = '0; col_idx = 0;
        drive();
        tick(3);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_code",  int'(key_code),  0);
        chk("rst_key_held",  int'(key_held),  0);
        chk("rst_multi_key", int'(multi_key), 0);
        rst_n = 1'b1;
        tick(8);

        // Clean press of key 5, frame-aligned: 4th frame closes at edge 16.
        align();
        press(key_bit(5));
        tick(16);
        chk("press5_early", int'(key_valid), 0);
        tick(1);
        chk("press5_valid", int'(key_valid), 1);
        chk("press5_code",  int'(key_code),  5);
        chk("press5_held",  int'(key_held),  1);
        tick(40);
        chk("press5_hold", int'(key_valid), 1);
        accept();
        chk("press5_drop", int'(key_valid), 0);
        chk("press5_events", dut_events, 1);
        tick(40);
        chk("press5_no_repeat", int'(key_valid), 0);
        chk("press5_events_after", dut_events, 1);
        press('0);
        tick(30);
        chk("press5_released", int'(key_held), 0);

        // Bounce on key 9: on, off, on, then hold; frames 3..6 agree.
        align();
        for (int i = 0; i < 3; i++) begin
            press((i == 1) ? '0 : key_bit(9));
            tick(4);
        end
        press(key_bit(9));
        tick(12);
        chk("bounce9_early", int'(key_valid), 0);
        tick(1);
        chk("bounce9_valid", int'(key_valid), 1);
        chk("bounce9_code",  int'(key_code),  9);
        accept();
        chk("bounce9_events", dut_events, 2);
        chk("bounce9_last",   last_code,  9);
        press('0);
        tick(30);

        // Two keys together are rejected until full release.
        press(key_bit(2) | key_bit(7));
        tick(30);
        chk("multi_flag",  int'(multi_key), 1);
        chk("multi_held",  int'(key_held),  1);
        chk("multi_valid", int'(key_valid), 0);
        press(key_bit(2));
        tick(30);
        chk("multi_partial_valid", int'(key_valid), 0);
        chk("multi_partial_flag",  int'(multi_key), 0);
        chk("multi_partial_held",  int'(key_held),  1);
        press('0);
        tick(30);
        chk("multi_released", int'(key_held), 0);
        press(key_bit(7));
        tick(30);
        chk("key7_valid", int'(key_valid), 1);
        chk("key7_code",  int'(key_code),  7);
        accept();
        chk("key7_events", dut_events, 3);
        press('0);
        tick(30);

        // Release while the event is still pending.
        press(key_bit(0));
        wait_valid(40, "key0_seen");
        chk("key0_code", int'(key_code), 0);
        press('0);
        tick(30);
        chk("key0_still_valid", int'(key_valid), 1);
        chk("key0_still_code",  int'(key_code),  0);
        chk("key0_held_gone",   int'(key_held),  0);
        accept();
        chk("key0_drop", int'(key_valid), 0);
        tick(30);
        chk("key0_no_more", int'(key_valid), 0);
        chk("key0_events",  dut_events, 4);

        // Asynchronous reset with an event pending.
        press(key_bit(11));
        wait_valid(40, "key11_seen");
        chk("key11_code", int'(key_code), 11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(key_valid), 0);
        chk("async_rst_code",  int'(key_code),  0);
        chk("async_rst_held",  int'(key_held),  0);
        chk("async_rst_multi", int'(multi_key), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_quiet", int'(key_valid), 0);
        wait_valid(40, "key11_refire");
        chk("key11_refire_code", int'(key_code), 11);
        accept();
        chk("key11_events", dut_events, 5);
        chk("key11_last",   last_code, 11);
        press('0);
        tick(30);

        // Last key, frame-aligned: lives in the frame-closing column.
        align();
        press(key_bit(15));
        tick(16);
        chk("key15_early", int'(key_valid), 0);
        tick(1);
        chk("key15_valid", int'(key_valid), 1);
        chk("key15_code",  int'(key_code),  15);
        accept();
        press('0);
        tick(30);
        chk("key15_released", int'(key_held), 0);

        // One-cycle glitch on key 15 must not persist past its frame.
        align();
        tick(3);
        press(key_bit(15));
        tick(1);
        press('0);
        tick(40);
        chk("glitch_held",   int'(key_held),  0);
        chk("glitch_valid",  int'(key_valid), 0);
        chk("glitch_events", dut_events, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
